// File: rtl/uart_bcd_frame_sender_pkg.sv
// Shared constants and FSM encoding for the BCD-to-ASCII frame sender.
package uart_bcd_frame_sender_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_CR   = 3'd2,
    ST_LF   = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

endpackage

// File: rtl/uart_bcd_frame_sender_if.sv
// Byte stream toward the UART transmitter: valid/ready handshake, one byte per transfer.
interface uart_bcd_frame_sender_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_bcd_frame_sender_bcd_nibble_ascii.sv
// One BCD nibble to its ASCII digit; non-decimal codes become '?' so bad data stays visible.
module bcd_nibble_ascii
  import uart_bcd_frame_sender_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] ascii
);
  always_comb begin
    ascii = ASCII_QMARK;
    if (nib <= 4'd9) ascii = ASCII_ZERO + {4'h0, nib};
  end
endmodule

// File: rtl/uart_bcd_frame_sender.sv
// Snapshots a packed-BCD value and streams it MSD first as ASCII, optionally followed by CR/LF.
module uart_bcd_frame_sender
  import uart_bcd_frame_sender_pkg::*;
#(
  parameter int NDIGITS   = 8,
  parameter int SEND_CRLF = 1,
  parameter int LZ_BLANK  = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NDIGITS-1:0]   bcd_in,
  uart_bcd_frame_sender_if.master tx,
  output logic                   busy,
  output logic                   done
);
  localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  state_t               state, nstate;
  logic [4*NDIGITS-1:0] snap, nsnap;
  logic [IDX_W-1:0]     idx, nidx, first_idx;
  logic [7:0]           ndata, asc;
  logic                 nvalid, loading, xfer;
  logic [3:0]           nib;
  int                   sel;

  assign loading = (state == ST_IDLE) || (state == ST_FIN);
  assign xfer    = tx.tx_valid && tx.tx_ready;
  assign busy    = (state == ST_SEND) || (state == ST_CR) || (state == ST_LF);
  assign done    = (state == ST_FIN);

  // Highest nonzero digit wins; an all-zero value falls back to the LSD.
  always_comb begin
    first_idx = IDX_W'(NDIGITS - 1);
    if (LZ_BLANK != 0) begin
      first_idx = '0;
      for (int i = 0; i < NDIGITS; i++)
        if (bcd_in[4*i +: 4] != 4'd0) first_idx = IDX_W'(i);
    end
  end

  // Single converter: the fresh input while loading, else the digit after the current one.
  always_comb begin
    sel = 0;
    if (loading)       sel = int'(first_idx);
    else if (idx != 0) sel = int'(idx) - 1;
    nib = loading ? 4'(bcd_in >> (4*sel)) : 4'(snap >> (4*sel));
  end

  bcd_nibble_ascii u_conv (.nib(nib), .ascii(asc));

  always_comb begin
    nstate = state;
    nsnap  = snap;
    nidx   = idx;
    ndata  = tx.tx_data;
    nvalid = tx.tx_valid;
    case (state)
      ST_IDLE, ST_FIN: begin
        nstate = ST_IDLE;
        if (start) begin
          nstate = ST_SEND;
          nsnap  = bcd_in;
          nidx   = first_idx;
          ndata  = asc;
          nvalid = 1'b1;
        end
      end
      ST_SEND: if (xfer) begin
        if (idx == 0) begin
          if (SEND_CRLF != 0) begin
            nstate = ST_CR;
            ndata  = ASCII_CR;
          end else begin
            nstate = ST_FIN;
            nvalid = 1'b0;
          end
        end else begin
          nidx  = idx - 1'b1;
          ndata = asc;
        end
      end
      ST_CR: if (xfer) begin
        nstate = ST_LF;
        ndata  = ASCII_LF;
      end
      ST_LF: if (xfer) begin
        nstate = ST_FIN;
        nvalid = 1'b0;
      end
      default: begin
        nstate = ST_IDLE;
        nvalid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      snap        <= '0;
      idx         <= '0;
      tx.tx_data  <= 8'h00;
      tx.tx_valid <= 1'b0;
    end else begin
      state       <= nstate;
      snap        <= nsnap;
      idx         <= nidx;
      tx.tx_data  <= ndata;
      tx.tx_valid <= nvalid;
    end
  end
endmodule
